// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared state encoding, defaults and priority scan for the INTA sequencer
package pic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_ACK1    = 2'd2,
    ST_ACK2    = 2'd3
  } pic_state_e;

  localparam logic [2:0] SPURIOUS_LEVEL_DEFAULT = 3'd7;

  // Highest-priority set bit, where base is the lowest priority and base+1 the highest.
  function automatic logic [2:0] pri_scan(input logic [7:0] vec, input logic [2:0] base);
    logic [2:0] idx;
    logic       found;
    pri_scan = '0;
    found    = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = base + 3'(i);
      if (!found && vec[idx]) begin
        pri_scan = idx;
        found    = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/pic_inta_sequencer_if.sv
// rtl/pic_inta_sequencer_if.sv - control, resolver, ISR and bus-buffer signals of the INTA sequencer
interface pic_inta_sequencer_if;
  logic       init_done;
  logic [4:0] icw2_vec;
  logic       aeoi;
  logic       int_req;
  logic [2:0] int_level;
  logic [2:0] pri_base;
  logic       inta_n;
  logic       eoi_cmd;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       eoi_rotate;
  logic       int_out;
  logic       irr_freeze;
  logic [7:0] isr;
  logic [7:0] vec_data;
  logic       vec_oe;
  logic       rotate_pulse;
  logic [2:0] rotate_level;
  logic       spurious;

  modport master (
    output init_done, icw2_vec, aeoi, int_req, int_level, pri_base, inta_n,
           eoi_cmd, eoi_specific, eoi_level, eoi_rotate,
    input  int_out, irr_freeze, isr, vec_data, vec_oe, rotate_pulse, rotate_level, spurious
  );

  modport slave (
    input  init_done, icw2_vec, aeoi, int_req, int_level, pri_base, inta_n,
           eoi_cmd, eoi_specific, eoi_level, eoi_rotate,
    output int_out, irr_freeze, isr, vec_data, vec_oe, rotate_pulse, rotate_level, spurious
  );
endinterface

// File: rtl/pic_edge_sync.sv
// rtl/pic_edge_sync.sv - multi-flop synchroniser with one-cycle fall/rise pulses
module pic_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic fall,
  output logic rise
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_in};
    prev_d = sync_q[STAGES-1];
  end

  // Idle level of an active-low strobe is 1, so reset must not fake an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign fall = prev_q & ~sync_q[STAGES-1];
  assign rise = ~prev_q & sync_q[STAGES-1];

endmodule

// File: rtl/pic_inta_sequencer.sv
// rtl/pic_inta_sequencer.sv - 8086-mode two-pulse INTA sequencer with ISR set/clear and EOI handling
module pic_inta_sequencer
  import pic_pkg::*;
#(
  parameter int         SYNC_STAGES    = 2,
  parameter logic [2:0] SPURIOUS_LEVEL = SPURIOUS_LEVEL_DEFAULT
) (
  input logic                 clk,
  input logic                 rst_n,
  pic_inta_sequencer_if.slave bus
);

  logic inta_fall, inta_rise;

  pic_edge_sync #(.STAGES(SYNC_STAGES)) u_inta_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (bus.inta_n),
    .fall     (inta_fall),
    .rise     (inta_rise)
  );

  pic_state_e state_q, state_d;
  logic       int_out_q, int_out_d;
  logic       irr_freeze_q, irr_freeze_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] vec_data_q, vec_data_d;
  logic       vec_oe_q, vec_oe_d;
  logic       rotate_pulse_q, rotate_pulse_d;
  logic [2:0] rotate_level_q, rotate_level_d;
  logic       spurious_q, spurious_d;
  logic [2:0] lvl_q, lvl_d;
  logic       spur_q, spur_d;

  logic [7:0] set_mask, clr_mask;
  logic [2:0] eoi_tgt;

  always_comb begin
    state_d        = state_q;
    int_out_d      = int_out_q;
    irr_freeze_d   = irr_freeze_q;
    vec_data_d     = vec_data_q;
    vec_oe_d       = vec_oe_q;
    rotate_pulse_d = 1'b0;
    rotate_level_d = rotate_level_q;
    spurious_d     = 1'b0;
    lvl_d          = lvl_q;
    spur_d         = spur_q;
    set_mask       = '0;
    clr_mask       = '0;
    eoi_tgt        = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.int_req) begin
          state_d   = ST_PENDING;
          int_out_d = 1'b1;
        end
      end
      ST_PENDING: begin
        if (inta_fall) begin
          lvl_d        = bus.int_req ? bus.int_level : SPURIOUS_LEVEL;
          spur_d       = ~bus.int_req;
          spurious_d   = ~bus.int_req;
          irr_freeze_d = 1'b1;
          int_out_d    = 1'b0;
          if (bus.int_req) set_mask = 8'(1) << bus.int_level;
          state_d      = ST_ACK1;
        end
      end
      ST_ACK1: begin
        if (inta_rise) state_d = ST_ACK2;
      end
      ST_ACK2: begin
        if (inta_fall) begin
          vec_data_d = {bus.icw2_vec, lvl_q};
          vec_oe_d   = 1'b1;
        end else if (inta_rise && vec_oe_q) begin
          vec_oe_d     = 1'b0;
          irr_freeze_d = 1'b0;
          if (bus.aeoi && !spur_q) clr_mask = 8'(1) << lvl_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A clear only counts (and may rotate) when the targeted bit was actually in service.
    if (bus.eoi_cmd) begin
      eoi_tgt = bus.eoi_specific ? bus.eoi_level : pri_scan(isr_q, bus.pri_base);
      if (isr_q[eoi_tgt]) begin
        clr_mask = clr_mask | (8'(1) << eoi_tgt);
        if (bus.eoi_rotate) begin
          rotate_pulse_d = 1'b1;
          rotate_level_d = eoi_tgt;
        end
      end
    end

    isr_d = (isr_q & ~clr_mask) | set_mask;

    if (!bus.init_done) begin
      state_d        = ST_IDLE;
      int_out_d      = 1'b0;
      irr_freeze_d   = 1'b0;
      vec_oe_d       = 1'b0;
      isr_d          = '0;
      rotate_pulse_d = 1'b0;
      rotate_level_d = rotate_level_q;
      spurious_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      int_out_q      <= 1'b0;
      irr_freeze_q   <= 1'b0;
      isr_q          <= '0;
      vec_data_q     <= '0;
      vec_oe_q       <= 1'b0;
      rotate_pulse_q <= 1'b0;
      rotate_level_q <= '0;
      spurious_q     <= 1'b0;
      lvl_q          <= '0;
      spur_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      int_out_q      <= int_out_d;
      irr_freeze_q   <= irr_freeze_d;
      isr_q          <= isr_d;
      vec_data_q     <= vec_data_d;
      vec_oe_q       <= vec_oe_d;
      rotate_pulse_q <= rotate_pulse_d;
      rotate_level_q <= rotate_level_d;
      spurious_q     <= spurious_d;
      lvl_q          <= lvl_d;
      spur_q         <= spur_d;
    end
  end

  assign bus.int_out      = int_out_q;
  assign bus.irr_freeze   = irr_freeze_q;
  assign bus.isr          = isr_q;
  assign bus.vec_data     = vec_data_q;
  assign bus.vec_oe       = vec_oe_q;
  assign bus.rotate_pulse = rotate_pulse_q;
  assign bus.rotate_level = rotate_level_q;
  assign bus.spurious     = spurious_q;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// tb/tb_pic_inta_sequencer.sv - scenario and randomized bench for pic_inta_sequencer
module tb_pic_inta_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       init_done, aeoi, int_req, inta_n, eoi_cmd, eoi_specific, eoi_rotate;
  logic [4:0] icw2_vec;
  logic [2:0] int_level, pri_base, eoi_level;
  logic       int_out, irr_freeze, vec_oe, rotate_pulse, spurious;
  logic [7:0] isr, vec_data;
  logic [2:0] rotate_level;

  pic_inta_sequencer_if bus ();

  assign bus.init_done    = init_done;
  assign bus.icw2_vec     = icw2_vec;
  assign bus.aeoi         = aeoi;
  assign bus.int_req      = int_req;
  assign bus.int_level    = int_level;
  assign bus.pri_base     = pri_base;
  assign bus.inta_n       = inta_n;
  assign bus.eoi_cmd      = eoi_cmd;
  assign bus.eoi_specific = eoi_specific;
  assign bus.eoi_level    = eoi_level;
  assign bus.eoi_rotate   = eoi_rotate;
  assign int_out      = bus.int_out;
  assign irr_freeze   = bus.irr_freeze;
  assign isr          = bus.isr;
  assign vec_data     = bus.vec_data;
  assign vec_oe       = bus.vec_oe;
  assign rotate_pulse = bus.rotate_pulse;
  assign rotate_level = bus.rotate_level;
  assign spurious     = bus.spurious;

  pic_inta_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int tests_run = 0;
  int tests_failed = 0;
  int spur_cnt = 0;
  int rot_cnt = 0;
  logic [7:0] model_isr = 8'h00;

  always @(negedge clk) begin
    if (spurious === 1'b1) spur_cnt <= spur_cnt + 1;
    if (rotate_pulse === 1'b1) rot_cnt <= rot_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [2:0] ref_highest(input logic [7:0] v, input int base);
    for (int k = 1; k <= 8; k++) begin
      int idx;
      idx = (base + k) % 8;
      if (v[idx]) return idx[2:0];
    end
    return 3'd0;
  endfunction

  task automatic test_reset();
    tests_run++; if (int_out !== 1'b0) begin tests_failed++; $display("FAIL reset_int_out got %b want 0", int_out); end
    tests_run++; if (irr_freeze !== 1'b0) begin tests_failed++; $display("FAIL reset_irr_freeze got %b want 0", irr_freeze); end
    tests_run++; if (isr !== 8'h00) begin tests_failed++; $display("FAIL reset_isr got %h want 00", isr); end
    tests_run++; if (vec_data !== 8'h00 || vec_oe !== 1'b0) begin tests_failed++; $display("FAIL reset_vec got %h/%b want 00/0", vec_data, vec_oe); end
    tests_run++; if (rotate_pulse !== 1'b0 || rotate_level !== 3'd0 || spurious !== 1'b0) begin
      tests_failed++; $display("FAIL reset_rot_spur got %b/%0d/%b want 0/0/0", rotate_pulse, rotate_level, spurious); end
  endtask

  // Full two-pulse acknowledge; drop=1 withdraws the request before the first INTA.
  task automatic run_ack(input bit aeoi_v, input bit drop, input logic [2:0] lvl, input logic [4:0] vec5);
    logic [2:0] el;
    int sp0, rp0;
    el = drop ? 3'd7 : lvl;
    aeoi = aeoi_v; icw2_vec = vec5; int_level = lvl; int_req = 1'b1;
    sp0 = spur_cnt; rp0 = rot_cnt;
    tests_run++; if (int_out !== 1'b0) begin tests_failed++; $display("FAIL ack_int_pre got %b want 0", int_out); end
    tick();
    tests_run++; if (int_out !== 1'b1) begin tests_failed++; $display("FAIL ack_int_out got %b want 1", int_out); end
    if (drop) begin int_req = 1'b0; tick(2); end
    inta_n = 1'b0; tick(4);
    if (!drop) model_isr = model_isr | (8'd1 << lvl);
    tests_run++; if (int_out !== 1'b0 || irr_freeze !== 1'b1) begin
      tests_failed++; $display("FAIL ack1_flags int_out=%b irr_freeze=%b want 0/1", int_out, irr_freeze); end
    tests_run++; if (isr !== model_isr) begin tests_failed++; $display("FAIL ack1_isr got %h want %h", isr, model_isr); end
    tests_run++; if (spur_cnt - sp0 != int'(drop)) begin tests_failed++; $display("FAIL ack1_spurious got %0d want %0d", spur_cnt - sp0, int'(drop)); end
    int_req = 1'b0; inta_n = 1'b1; tick(4);
    inta_n = 1'b0; tick(4);
    tests_run++; if (vec_oe !== 1'b1 || vec_data !== {vec5, el}) begin
      tests_failed++; $display("FAIL ack2_vector got %h oe=%b want %h oe=1", vec_data, vec_oe, {vec5, el}); end
    inta_n = 1'b1; tick(4);
    if (aeoi_v && !drop) model_isr = model_isr & ~(8'd1 << lvl);
    tests_run++; if (vec_oe !== 1'b0 || irr_freeze !== 1'b0 || int_out !== 1'b0) begin
      tests_failed++; $display("FAIL ack_end_flags oe=%b frz=%b int=%b want 0/0/0", vec_oe, irr_freeze, int_out); end
    tests_run++; if (isr !== model_isr) begin tests_failed++; $display("FAIL ack_end_isr got %h want %h", isr, model_isr); end
    tests_run++; if (rot_cnt != rp0) begin tests_failed++; $display("FAIL ack_no_rotate got %0d pulses want 0", rot_cnt - rp0); end
    aeoi = 1'b0;
  endtask

  task automatic do_eoi(input bit spec, input logic [2:0] lv, input bit rot, input logic [2:0] base);
    logic [2:0] tgt;
    bit hit;
    tgt = spec ? lv : ref_highest(model_isr, int'(base));
    hit = model_isr[tgt];
    eoi_cmd = 1'b1; eoi_specific = spec; eoi_level = lv; eoi_rotate = rot; pri_base = base;
    tick();
    eoi_cmd = 1'b0; eoi_specific = 1'b0; eoi_rotate = 1'b0;
    if (hit) model_isr[tgt] = 1'b0;
    tests_run++; if (rotate_pulse !== (rot && hit)) begin
      tests_failed++; $display("FAIL eoi_rotate_pulse got %b want %b", rotate_pulse, rot && hit); end
    if (rot && hit) begin
      tests_run++; if (rotate_level !== tgt) begin tests_failed++; $display("FAIL eoi_rotate_level got %0d want %0d", rotate_level, tgt); end
    end
    tests_run++; if (isr !== model_isr) begin tests_failed++; $display("FAIL eoi_isr got %h want %h", isr, model_isr); end
    tick();
    tests_run++; if (rotate_pulse !== 1'b0) begin tests_failed++; $display("FAIL eoi_pulse_width got %b want 0", rotate_pulse); end
  endtask

  task automatic test_basic();
    run_ack(1'b0, 1'b0, 3'd3, 5'b00100);
    tests_run++; if (isr !== 8'h08) begin tests_failed++; $display("FAIL basic_isr got %h want 08", isr); end
    do_eoi(1'b1, 3'd3, 1'b0, 3'd7);
  endtask

  task automatic test_aeoi();
    run_ack(1'b1, 1'b0, 3'd3, 5'b00100);
    tests_run++; if (isr !== 8'h00) begin tests_failed++; $display("FAIL aeoi_isr got %h want 00", isr); end
  endtask

  task automatic test_spurious();
    run_ack(1'b0, 1'b1, 3'd3, 5'b00100);
    tests_run++; if (vec_data !== 8'h27) begin tests_failed++; $display("FAIL spurious_vec got %h want 27", vec_data); end
  endtask

  task automatic test_eoi_rotate();
    run_ack(1'b0, 1'b0, 3'd2, 5'b10101);
    run_ack(1'b0, 1'b0, 3'd5, 5'b10101);
    tests_run++; if (isr !== 8'h24) begin tests_failed++; $display("FAIL rot_setup_isr got %h want 24", isr); end
    do_eoi(1'b0, 3'd0, 1'b1, 3'd3);
    tests_run++; if (isr !== 8'h04) begin tests_failed++; $display("FAIL rot_isr got %h want 04", isr); end
    do_eoi(1'b0, 3'd0, 1'b0, 3'd3);
    do_eoi(1'b0, 3'd0, 1'b1, 3'd3);
  endtask

  task automatic test_simul_set_clear();
    run_ack(1'b0, 1'b0, 3'd0, 5'b00001);
    int_req = 1'b1; int_level = 3'd0; tick();
    inta_n = 1'b0; tick(2);
    eoi_cmd = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd0; eoi_rotate = 1'b0;
    tick();
    eoi_cmd = 1'b0; eoi_specific = 1'b0;
    tests_run++; if (isr !== 8'h01) begin tests_failed++; $display("FAIL simul_set_wins got %h want 01", isr); end
    int_req = 1'b0; tick(2);
    inta_n = 1'b1; tick(4); inta_n = 1'b0; tick(4); inta_n = 1'b1; tick(4);
    do_eoi(1'b1, 3'd0, 1'b0, pri_base);
    tests_run++; if (isr !== 8'h00) begin tests_failed++; $display("FAIL simul_clear got %h want 00", isr); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 2) == 0)
        do_eoi(1'(($urandom_range(0, 1))), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      else
        run_ack(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
    end
  endtask

  task automatic test_abort();
    int_req = 1'b1; int_level = 3'd4; tick();
    inta_n = 1'b0; tick(4);
    tests_run++; if (irr_freeze !== 1'b1 || isr[4] !== 1'b1) begin
      tests_failed++; $display("FAIL abort_setup frz=%b isr=%h want 1/bit4", irr_freeze, isr); end
    init_done = 1'b0; tick();
    tests_run++; if (isr !== 8'h00 || irr_freeze !== 1'b0 || int_out !== 1'b0 || vec_oe !== 1'b0) begin
      tests_failed++; $display("FAIL abort_clear isr=%h frz=%b int=%b oe=%b want 00/0/0/0", isr, irr_freeze, int_out, vec_oe); end
    int_req = 1'b0; inta_n = 1'b1; tick(4);
    init_done = 1'b1; model_isr = 8'h00;
    for (int k = 0; k < 3; k++) begin inta_n = 1'b0; tick(4); inta_n = 1'b1; tick(4); end
    tests_run++; if (isr !== 8'h00 || int_out !== 1'b0 || vec_oe !== 1'b0 || irr_freeze !== 1'b0) begin
      tests_failed++; $display("FAIL idle_inta_ignored isr=%h int=%b oe=%b frz=%b", isr, int_out, vec_oe, irr_freeze); end
  endtask

  task automatic test_reset_mid_ack2();
    icw2_vec = 5'b11111; int_req = 1'b1; int_level = 3'd6; tick();
    inta_n = 1'b0; tick(4); int_req = 1'b0; inta_n = 1'b1; tick(4); inta_n = 1'b0; tick(4);
    tests_run++; if (vec_oe !== 1'b1 || vec_data !== 8'hFE) begin
      tests_failed++; $display("FAIL rst_setup oe=%b vec=%h want 1/fe", vec_oe, vec_data); end
    #2 rst_n = 1'b0; #1;
    tests_run++; if (int_out !== 1'b0 || irr_freeze !== 1'b0 || vec_oe !== 1'b0 || isr !== 8'h00 ||
                     vec_data !== 8'h00 || rotate_pulse !== 1'b0 || spurious !== 1'b0) begin
      tests_failed++; $display("FAIL async_reset oe=%b vec=%h isr=%h frz=%b want all 0", vec_oe, vec_data, isr, irr_freeze); end
    inta_n = 1'b1; tick(2); rst_n = 1'b1; tick(3);
    model_isr = 8'h00;
  endtask

  initial begin
    init_done = 1'b1; aeoi = 1'b0; int_req = 1'b0; inta_n = 1'b1;
    eoi_cmd = 1'b0; eoi_specific = 1'b0; eoi_rotate = 1'b0;
    icw2_vec = 5'd0; int_level = 3'd0; pri_base = 3'd7; eoi_level = 3'd0;
    tick(3);
    test_reset();
    rst_n = 1'b1; tick(2);
    test_reset();
    test_basic();
    test_aeoi();
    test_spurious();
    test_eoi_rotate();
    test_simul_set_clear();
    test_random();
    test_abort();
    test_reset_mid_ack2();
    test_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
